control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 175 +++++++++++++++++
 tb/tb_control_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: three-state instruction sequencer (IDLE -> EXEC -> WB).
// An accepted instruction word is decoded once and its control/address fields
// are held stable until the next accept. EXEC lasts EXEC_CYCLES cycles and WB
// lasts one cycle; the write, branch and illegal strobes pulse only in WB.
// Optional feature macro: ALU_SHIFT_OPS_EN enables the sll (0x08) and
// srl (0x09) opcodes; without it both opcodes are illegal and alu_shift is 0.
module control_sequencer #(
  parameter int unsigned EXEC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        alu_zero,
  output logic [2:0]  alu_select,
  output logic        alu_shift,
  output logic        imm_sel,
  output logic        neg_sel,
  output logic [2:0]  read_addr1,
  output logic [2:0]  read_addr2,
  output logic [2:0]  write_addr,
  output logic [7:0]  immediate,
  output logic        reg_write,
  output logic        branch_taken,
  output logic [7:0]  offset,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  typedef struct packed {
    logic       legal;
    logic [2:0] sel;
    logic       shift;
    logic       imm;
    logic       neg;
    logic       write;
    logic       jump;
    logic       beq;
  } decode_t;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t  state, state_next;
  logic [3:0] cnt, cnt_next;
  logic    accept, enter_wb, exec_done;
  decode_t dec;
  logic    pend_write, pend_jump, pend_beq;

  // instr[15:11] carries no meaning for a 3-bit register address.
  logic unused_bits;
  assign unused_bits = ^instr[15:11];

  assign instr_ready = (state == IDLE);

  // Decode the opcode currently presented on instr.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    dec = '0;
    case (instr[31:24])
      8'h00: begin dec.legal = 1'b1; dec.imm = 1'b1; dec.write = 1'b1; end
      8'h01: begin dec.legal = 1'b1; dec.write = 1'b1; end
      8'h02: begin dec.legal = 1'b1; dec.sel = 3'b001; dec.write = 1'b1; end
      8'h03: begin dec.legal = 1'b1; dec.sel = 3'b001; dec.neg = 1'b1; dec.write = 1'b1; end
      8'h04: begin dec.legal = 1'b1; dec.sel = 3'b010; dec.write = 1'b1; end
      8'h05: begin dec.legal = 1'b1; dec.sel = 3'b011; dec.write = 1'b1; end
      8'h06: begin dec.legal = 1'b1; dec.jump = 1'b1; end
      8'h07: begin dec.legal = 1'b1; dec.sel = 3'b001; dec.neg = 1'b1; dec.beq = 1'b1; end
`ifdef ALU_SHIFT_OPS_EN
      8'h08: begin dec.legal = 1'b1; dec.sel = 3'b100; dec.imm = 1'b1; dec.write = 1'b1; end
      8'h09: begin
        dec.legal = 1'b1; dec.sel = 3'b100; dec.shift = 1'b1; dec.imm = 1'b1; dec.write = 1'b1;
      end
`else
      8'h08, 8'h09: dec = '0;
`endif
      default: dec = '0;
    endcase
  end

  // Next-state logic: accept in IDLE, count down in EXEC, single-cycle WB.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    enter_wb   = 1'b0;
    exec_done  = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          accept = 1'b1;
          if (dec.legal) begin
            state_next = EXEC;
            cnt_next   = CNT_LOAD;
          end else begin
            state_next = WB;
            enter_wb   = 1'b1;
          end
        end
      end
      EXEC: begin
        if (cnt == 4'd0) begin
          state_next = WB;
          enter_wb   = 1'b1;
          exec_done  = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and EXEC down-counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Capture decoded controls and instruction fields at accept; hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_select <= 3'b000;
      alu_shift  <= 1'b0;
      imm_sel    <= 1'b0;
      neg_sel    <= 1'b0;
      read_addr1 <= 3'd0;
      read_addr2 <= 3'd0;
      write_addr <= 3'd0;
      immediate  <= 8'd0;
      offset     <= 8'd0;
      pend_write <= 1'b0;
      pend_jump  <= 1'b0;
      pend_beq   <= 1'b0;
    end else if (accept) begin
      alu_select <= dec.sel;
      alu_shift  <= dec.shift;
      imm_sel    <= dec.imm;
      neg_sel    <= dec.neg;
      read_addr1 <= instr[10:8];
      read_addr2 <= instr[2:0];
      write_addr <= instr[18:16];
      immediate  <= instr[7:0];
      offset     <= instr[23:16];
      pend_write <= dec.write;
      pend_jump  <= dec.jump;
      pend_beq   <= dec.beq;
    end
  end

  // WB strobes: set on the edge entering WB, self-clearing one cycle later.
  // beq samples alu_zero on the edge that ends the last EXEC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write    <= 1'b0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      reg_write    <= exec_done & pend_write;
      branch_taken <= exec_done & (pend_jump | (pend_beq & alu_zero));
      illegal      <= enter_wb & ~exec_done;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a cycle-indexed behavioural model
// (accept time, scheduled write-back time) is compared against the DUT on
// every falling edge, and directed scenarios pin the model with literals.
module tb_control_sequencer;

  localparam int E = 2;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        alu_zero;
  logic [2:0]  alu_select;
  logic        alu_shift;
  logic        imm_sel;
  logic        neg_sel;
  logic [2:0]  read_addr1;
  logic [2:0]  read_addr2;
  logic [2:0]  write_addr;
  logic [7:0]  immediate;
  logic        reg_write;
  logic        branch_taken;
  logic [7:0]  offset;
  logic        illegal;

  control_sequencer #(.EXEC_CYCLES(E)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_zero(alu_zero), .alu_select(alu_select),
    .alu_shift(alu_shift), .imm_sel(imm_sel), .neg_sel(neg_sel),
    .read_addr1(read_addr1), .read_addr2(read_addr2), .write_addr(write_addr),
    .immediate(immediate), .reg_write(reg_write), .branch_taken(branch_taken),
    .offset(offset), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       legal;
    logic [2:0] sel;
    logic       shift;
    logic       imm;
    logic       neg;
    logic       write;
    logic       jump;
    logic       beq;
  } op_t;

  // Opcode table from the instruction set description.
  function automatic op_t op_info(input logic [7:0] opc);
    op_t o;
    o = '0;
    case (opc)
      8'h00: o = '{1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      8'h01: o = '{1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      8'h02: o = '{1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      8'h03: o = '{1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      8'h04: o = '{1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      8'h05: o = '{1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      8'h06: o = '{1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      8'h07: o = '{1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`ifdef ALU_SHIFT_OPS_EN
      8'h08: o = '{1'b1, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      8'h09: o = '{1'b1, 3'b100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`endif
      default: o = '0;
    endcase
    return o;
  endfunction

  bit          model_on = 1'b0;
  bit          busy     = 1'b0;
  int          edge_no  = 0;
  int          wb_at    = 0;
  op_t         cur;
  logic [30:0] exp_ctrl = '0;
  logic        m_write, m_taken, m_illegal;

  // Model: an instruction accepted at edge n owns the sequencer until edge
  // wb_at+1, where wb_at = n+E (legal) or n (illegal); strobes appear at wb_at.
  always @(posedge clk) begin
    bit was_idle;
    op_t o;
    model_on = 1'b1;
    edge_no++;
    m_write = 1'b0; m_taken = 1'b0; m_illegal = 1'b0;
    if (reset) begin
      busy     = 1'b0;
      exp_ctrl = '0;
    end else begin
      was_idle = !busy;
      if (busy && edge_no == wb_at + 1) busy = 1'b0;
      if (was_idle && instr_valid) begin
        o     = op_info(instr[31:24]);
        cur   = o;
        busy  = 1'b1;
        wb_at = edge_no + (o.legal ? E : 0);
        exp_ctrl = {o.sel, o.shift, o.imm, o.neg, instr[10:8], instr[2:0],
                    instr[18:16], instr[7:0], instr[23:16]};
      end
      if (busy && edge_no == wb_at) begin
        m_write   = cur.legal && cur.write;
        m_taken   = cur.jump || (cur.beq && alu_zero);
        m_illegal = !cur.legal;
      end
    end
  end

  // Compare every cycle once the model has seen its first edge.
  always @(negedge clk) begin
    if (model_on) begin
      check("ready", instr_ready, !busy);
      check("ctrl", {alu_select, alu_shift, imm_sel, neg_sel, read_addr1, read_addr2,
                     write_addr, immediate, offset}, exp_ctrl);
      check("strobes", {reg_write, branch_taken, illegal}, {m_write, m_taken, m_illegal});
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic send(input logic [31:0] w, input logic z);
    int n;
    n = 0;
    while (!instr_ready && n < 32) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) check("send_wait_ready", instr_ready, 1);
    instr       = w;
    alu_zero    = z;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  // Falling-edge index (1 = first cycle after accept) of each strobe and of ready.
  task automatic watch(output int w_at, output int b_at, output int i_at, output int r_at);
    w_at = 0; b_at = 0; i_at = 0; r_at = 0;
    for (int k = 1; k <= 16; k++) begin
      if (reg_write && w_at == 0) w_at = k;
      if (branch_taken && b_at == 0) b_at = k;
      if (illegal && i_at == 0) i_at = k;
      if (instr_ready) begin
        r_at = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  int w_at, b_at, i_at, r_at;
  int acc[3];
  logic [31:0] seq_list[3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = '0; alu_zero = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", instr_ready, 1);
    check("reset_strobes", {reg_write, branch_taken, illegal}, 0);
    check("reset_select", alu_select, 0);

    // add on the first edge with reset low
    reset = 1'b0;
    send(32'h02_03_01_02, 1'b0);
    check("add_select", alu_select, 3'b001);
    check("add_addrs", {read_addr1, read_addr2, write_addr}, {3'd1, 3'd2, 3'd3});
    watch(w_at, b_at, i_at, r_at);
    check("add_write_at", w_at, 3);
    check("add_no_branch", b_at, 0);
    check("add_ready_at", r_at, 4);

    // beq taken
    send(32'h07_FC_01_02, 1'b1);
    check("beq_offset", offset, 8'hFC);
    check("beq_neg_sel", neg_sel, 1);
    watch(w_at, b_at, i_at, r_at);
    check("beq1_branch_at", b_at, 3);
    check("beq1_no_write", w_at, 0);

    // beq not taken
    send(32'h07_FC_01_02, 1'b0);
    watch(w_at, b_at, i_at, r_at);
    check("beq0_no_branch", b_at, 0);
    check("beq0_ready_at", r_at, 4);

    // illegal opcode
    send(32'h0F_00_00_00, 1'b0);
    watch(w_at, b_at, i_at, r_at);
    check("ill_at", i_at, 1);
    check("ill_no_write", w_at, 0);
    check("ill_ready_at", r_at, 2);

    // srl
    send(32'h09_02_01_03, 1'b0);
`ifdef ALU_SHIFT_OPS_EN
    check("srl_ctrl", {alu_select, alu_shift, imm_sel}, {3'b100, 1'b1, 1'b1});
    watch(w_at, b_at, i_at, r_at);
    check("srl_write_at", w_at, 3);
    check("srl_not_illegal", i_at, 0);
`else
    check("srl_shift_off", alu_shift, 0);
    watch(w_at, b_at, i_at, r_at);
    check("srl_illegal_at", i_at, 1);
    check("srl_no_write", w_at, 0);
`endif

    // reset in the first EXEC cycle of loadi
    send(32'h00_04_00_55, 1'b0);
    check("loadi_busy", instr_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready", instr_ready, 1);
    w_at = 0;
    for (int k = 0; k < 4; k++) begin
      if (reg_write) w_at = 1;
      @(negedge clk);
    end
    check("abort_no_write", w_at, 0);

    // valid held high across three instructions
    seq_list[0] = 32'h02_03_01_02;
    seq_list[1] = 32'h06_10_00_00;
    seq_list[2] = 32'h05_07_06_05;
    begin
      int c, n;
      c = 0; n = 0;
      instr = seq_list[0];
      instr_valid = 1'b1;
      while (n < 3 && c < 40) begin
        if (instr_ready) begin
          acc[n] = c;
          n++;
          @(negedge clk);
          c++;
          if (n < 3) instr = seq_list[n];
          else instr_valid = 1'b0;
        end else begin
          @(negedge clk);
          c++;
        end
      end
      instr_valid = 1'b0;
      check("b2b_count", n, 3);
      check("b2b_gap1", acc[1] - acc[0], E + 2);
      check("b2b_gap2", acc[2] - acc[1], E + 2);
    end
    repeat (6) @(negedge clk);
    check("final_ready", instr_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
